sdram_device_model: RTL and testbench

Synthesizable single-chip SDR SDRAM responder that answers the controller's command pins: decode, per-bank row state, mode register, CAS-latency read pipeline and burst sequencing. It is backed by a small on-chip memory. It sits at the pin side of the controller (cmd/ba/addr/dqm/dq) and replaces a physical SDRAM in FPGA loopback builds and in the block-level bench. Protocol violations are flagged on a sticky error vector.

---
 rtl/sdram_device_model.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_device_model.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_device_model.sv
// Pin-level SDR SDRAM responder: command decode, bank rows, mode register, CL read pipe, bursts.
// Optional macro SDRAM_TIMING_CHECK_EN adds tRCD/tRP/tRFC/tMRD checking reported on err[4].
module sdram_device_model #(
    parameter int DW     = 16,
    parameter int RAW    = 12,
    parameter int CAW    = 9,
    parameter int MEM_AW = 12,
    parameter int tRCD_C = 2,
    parameter int tRP_C  = 2,
    parameter int tRFC_C = 7,
    parameter int tMRD_C = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdram_cs_n,
    input  logic              sdram_ras_n,
    input  logic              sdram_cas_n,
    input  logic              sdram_we_n,
    input  logic [1:0]        sdram_ba,
    input  logic [RAW-1:0]    sdram_addr,
    input  logic [DW/8-1:0]   sdram_dqm,
    input  logic [DW-1:0]     sdram_dq_in,
    output logic [DW-1:0]     sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic [RAW-1:0]    mode_reg,
    output logic [5:0]        err,
    output logic [15:0]       refresh_count
);
    localparam int BW = DW / 8;
    localparam int FW = 2 + RAW + CAW;

    function automatic logic mode_ok(input logic [6:0] m);
        return (m[2:0] <= 3'd3) && (m[6:4] == 3'd2 || m[6:4] == 3'd3) && !m[3];
    endfunction

    logic [3:0] w_cmd;
    logic       w_act, w_rd, w_wr, w_pre, w_ref, w_lmr, w_bst;
    assign w_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign w_act = (w_cmd == 4'b0011);
    assign w_rd  = (w_cmd == 4'b0101);
    assign w_wr  = (w_cmd == 4'b0100);
    assign w_pre = (w_cmd == 4'b0010);
    assign w_ref = (w_cmd == 4'b0001);
    assign w_lmr = (w_cmd == 4'b0000);
    assign w_bst = (w_cmd == 4'b0110);

    logic [RAW-1:0] r_mode;
    logic [5:0]     r_err, w_err_set;
    logic [15:0]    r_ref_cnt;
    logic [3:0]     r_open;
    logic [RAW-1:0] r_row [4];
    logic           w_mok, w_cl3, w_bank_open, w_any_open, w_tviol;
    logic [2:0]     w_rlast, w_wlast;

    // Unsupported mode falls back to BL1/CL2; lengths are kept as (BL-1).
    assign w_mok   = mode_ok(r_mode[6:0]);
    assign w_cl3   = w_mok && (r_mode[6:4] == 3'd3);
    assign w_rlast = w_mok ? 3'((4'd1 << r_mode[1:0]) - 4'd1) : 3'd0;
    assign w_wlast = r_mode[9] ? 3'd0 : w_rlast;
    assign w_bank_open = r_open[sdram_ba];
    assign w_any_open  = |r_open;

    logic           r_bst_act, r_bst_wr, r_bst_ap, r_ap_pend;
    logic [1:0]     r_bst_ba, r_ap_ba;
    logic [RAW-1:0] r_bst_row;
    logic [CAW-1:0] r_bst_col;
    logic [2:0]     r_bst_idx, r_bst_last;

    logic           w_new, w_beat, w_beat_wr, w_b_ap, w_b_done;
    logic [1:0]     w_b_ba;
    logic [RAW-1:0] w_b_row;
    logic [CAW-1:0] w_b_col0, w_mask, w_col;
    logic [2:0]     w_b_idx, w_b_last;
    logic [FW-1:0]  w_full;
    logic [MEM_AW-1:0] w_maddr;

    // A new accepted READ/WRITE takes this edge's beat and truncates any running burst.
    assign w_new = (w_rd || w_wr) && w_bank_open;
    always_comb begin
        w_beat    = 1'b0;
        w_beat_wr = r_bst_wr;
        w_b_ap    = r_bst_ap;
        w_b_ba    = r_bst_ba;
        w_b_row   = r_bst_row;
        w_b_col0  = r_bst_col;
        w_b_idx   = r_bst_idx;
        w_b_last  = r_bst_last;
        if (w_new) begin
            w_beat    = 1'b1;
            w_beat_wr = w_wr;
            w_b_ap    = sdram_addr[10];
            w_b_ba    = sdram_ba;
            w_b_row   = r_row[sdram_ba];
            w_b_col0  = sdram_addr[CAW-1:0];
            w_b_idx   = 3'd0;
            w_b_last  = w_wr ? w_wlast : w_rlast;
        end else if (r_bst_act) begin
            w_beat = 1'b1;
        end
    end
    assign w_b_done = (w_b_idx == w_b_last);
    assign w_mask   = CAW'(w_b_last);
    assign w_col    = (w_b_col0 & ~w_mask) | ((w_b_col0 + CAW'(w_b_idx)) & w_mask);
    assign w_full   = {w_b_ba, w_b_row, w_col};
    assign w_maddr  = MEM_AW'(w_full);

    logic [DW-1:0]     r_mem [2**MEM_AW];
    logic [2:1]        r_rd_vld;
    logic [MEM_AW-1:0] r_rd_addr [2:1];
    logic              w_out_vld, w_rd_pend;
    logic [MEM_AW-1:0] w_out_addr;
    logic [DW-1:0]     r_dq_out;
    logic              r_dq_oe;

    assign w_out_vld  = w_cl3 ? r_rd_vld[2]  : r_rd_vld[1];
    assign w_out_addr = w_cl3 ? r_rd_addr[2] : r_rd_addr[1];
    assign w_rd_pend  = r_rd_vld[1] || (w_cl3 && r_rd_vld[2]) || (r_bst_act && !r_bst_wr);

    assign w_err_set = {w_wr && w_rd_pend,
                        w_tviol,
                        w_lmr && !w_any_open && !mode_ok(sdram_addr[6:0]),
                        (w_lmr || w_ref) && w_any_open,
                        w_act && w_bank_open,
                        (w_rd || w_wr) && !w_bank_open};

    always_ff @(posedge clk) begin
        if (w_beat && w_beat_wr)
            for (int b = 0; b < BW; b++)
                if (!sdram_dqm[b]) r_mem[w_maddr][8*b +: 8] <= sdram_dq_in[8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open    <= '0;
            for (int b = 0; b < 4; b++) r_row[b] <= '0;
            r_mode    <= RAW'(12'h020);
            r_err     <= '0;
            r_ref_cnt <= '0;
            r_bst_act <= 1'b0;  r_bst_wr   <= 1'b0;  r_bst_ap  <= 1'b0;
            r_bst_ba  <= '0;    r_bst_row  <= '0;    r_bst_col <= '0;
            r_bst_idx <= '0;    r_bst_last <= '0;
            r_ap_pend <= 1'b0;  r_ap_ba    <= '0;
            r_rd_vld  <= '0;    r_rd_addr[1] <= '0;  r_rd_addr[2] <= '0;
            r_dq_out  <= '0;    r_dq_oe    <= 1'b0;
        end else begin
            r_err <= r_err | w_err_set;
            if (r_ap_pend) r_open[r_ap_ba] <= 1'b0;
            if (w_act && !w_bank_open) begin
                r_open[sdram_ba] <= 1'b1;
                r_row[sdram_ba]  <= sdram_addr;
            end
            if (w_pre) begin
                if (sdram_addr[10]) r_open <= '0;
                else                r_open[sdram_ba] <= 1'b0;
            end
            if (w_lmr && !w_any_open) r_mode <= sdram_addr;
            if (w_ref) r_ref_cnt <= r_ref_cnt + 16'd1;
            r_ap_pend <= 1'b0;
            if (w_beat) begin
                r_bst_act <= !(w_b_done || w_bst);
                r_bst_idx <= w_b_idx + 3'd1;
                if (w_new) begin
                    r_bst_wr   <= w_beat_wr;  r_bst_ap  <= w_b_ap;
                    r_bst_ba   <= w_b_ba;     r_bst_row <= w_b_row;
                    r_bst_col  <= w_b_col0;   r_bst_last <= w_b_last;
                end
                if (w_b_done) begin
                    r_ap_pend <= w_b_ap;
                    r_ap_ba   <= w_b_ba;
                end
            end
            r_rd_vld[1]  <= w_beat && !w_beat_wr;
            r_rd_addr[1] <= w_maddr;
            r_rd_vld[2]  <= r_rd_vld[1];
            r_rd_addr[2] <= r_rd_addr[1];
            r_dq_oe      <= w_out_vld;
            r_dq_out     <= w_out_vld ? r_mem[w_out_addr] : '0;
        end
    end

`ifdef SDRAM_TIMING_CHECK_EN
    logic [7:0] r_trcd [4];
    logic [7:0] r_trp  [4];
    logic [7:0] r_trfc, r_tmrd;
    logic       w_any_trp, w_busy;

    always_comb begin
        w_any_trp = 1'b0;
        for (int b = 0; b < 4; b++) if (r_trp[b] != 8'd0) w_any_trp = 1'b1;
    end
    assign w_busy  = (r_trfc != 8'd0) || (r_tmrd != 8'd0);
    assign w_tviol = (w_busy && !sdram_cs_n && (w_cmd != 4'b0111))
                  || ((w_rd || w_wr) && (r_trcd[sdram_ba] != 8'd0))
                  || (w_act && (r_trp[sdram_ba] != 8'd0))
                  || (w_ref && w_any_trp);

    // Counters are loaded with (t-1) so the command t edges later is the first legal one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                r_trcd[b] <= 8'd0;
                r_trp[b]  <= 8'd0;
            end
            r_trfc <= 8'd0;
            r_tmrd <= 8'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_trcd[b] != 8'd0) r_trcd[b] <= r_trcd[b] - 8'd1;
                if (r_trp[b]  != 8'd0) r_trp[b]  <= r_trp[b]  - 8'd1;
                if (w_act && (2'(b) == sdram_ba)) r_trcd[b] <= 8'(tRCD_C - 1);
                if (w_pre && (sdram_addr[10] || (2'(b) == sdram_ba))) r_trp[b] <= 8'(tRP_C - 1);
            end
            if (r_trfc != 8'd0) r_trfc <= r_trfc - 8'd1;
            if (r_tmrd != 8'd0) r_tmrd <= r_tmrd - 8'd1;
            if (w_ref) r_trfc <= 8'(tRFC_C - 1);
            if (w_lmr) r_tmrd <= 8'(tMRD_C - 1);
        end
    end
`else
    assign w_tviol = 1'b0;
`endif

    assign sdram_dq_out  = r_dq_out;
    assign sdram_dq_oe   = r_dq_oe;
    assign mode_reg      = r_mode;
    assign err           = r_err;
    assign refresh_count = r_ref_cnt;
endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: mode, bursts, bank errors, refresh, auto-precharge, timing.
module tb_sdram_device_model;
    localparam int DW = 16, RAW = 12, CAW = 9, MEM_AW = 12;

    logic clk = 1'b0, rst = 1'b1;
    logic cs_n, ras_n, cas_n, we_n;
    logic [1:0] ba;
    logic [RAW-1:0] addr;
    logic [1:0] dqm;
    logic [DW-1:0] dq_in, dq_out;
    logic dq_oe;
    logic [RAW-1:0] mode_reg;
    logic [5:0] err;
    logic [15:0] refresh_count;
    int checks = 0, failures = 0;
    logic [15:0] wdat [8];
    logic [1:0]  wdqm [8];
    logic [15:0] exp4 [4];

    sdram_device_model #(.DW(DW), .RAW(RAW), .CAW(CAW), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n),
        .sdram_we_n(we_n), .sdram_ba(ba), .sdram_addr(addr), .sdram_dqm(dqm),
        .sdram_dq_in(dq_in), .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe),
        .mode_reg(mode_reg), .err(err), .refresh_count(refresh_count));

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [RAW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] m);
        {cs_n, ras_n, cas_n, we_n} = c; ba = b; addr = a; dq_in = d; dqm = m;
        @(posedge clk); #1;
    endtask
    task automatic nop();                 drive(4'b0111, 2'd0, '0, '0, 2'b00); endtask
    task automatic idle(input int n);     repeat (n) nop(); endtask
    task automatic act(input logic [1:0] b, input logic [RAW-1:0] row); drive(4'b0011, b, row, '0, 2'b00); endtask
    task automatic lmr(input logic [RAW-1:0] v); drive(4'b0000, 2'd0, v, '0, 2'b00); endtask
    task automatic refr();                drive(4'b0001, 2'd0, '0, '0, 2'b00); endtask
    task automatic pre(input logic [1:0] b, input logic all);
        logic [RAW-1:0] a; a = '0; a[10] = all; drive(4'b0010, b, a, '0, 2'b00);
    endtask
    task automatic rd(input logic [1:0] b, input int col, input logic ap);
        logic [RAW-1:0] a; a = RAW'(col); a[10] = ap; drive(4'b0101, b, a, '0, 2'b00);
    endtask
    task automatic wr_burst(input logic [1:0] b, input int col, input logic ap, input int n);
        logic [RAW-1:0] a; a = RAW'(col); a[10] = ap;
        drive(4'b0100, b, a, wdat[0], wdqm[0]);
        for (int i = 1; i < n; i++) drive(4'b0111, 2'd0, '0, wdat[i], wdqm[i]);
    endtask
    task automatic do_reset();
        {cs_n, ras_n, cas_n, we_n} = 4'b0111; ba = '0; addr = '0; dq_in = '0; dqm = '0;
        rst = 1'b1; #3;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dq_out !== 16'h0) begin failures++; $display("FAIL reset_dq got=%h exp=0000", dq_out); end
        checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", dq_oe); end
        checks++; if (err !== 6'h0) begin failures++; $display("FAIL reset_err got=%b exp=000000", err); end
        checks++; if (refresh_count !== 16'h0) begin failures++; $display("FAIL reset_refcnt got=%0d exp=0", refresh_count); end
        checks++; if (mode_reg !== 12'h020) begin failures++; $display("FAIL reset_mode got=%h exp=020", mode_reg); end
    endtask

    task automatic test_cl3_rw();
        lmr(12'h030); idle(2);
        checks++; if (mode_reg !== 12'h030) begin failures++; $display("FAIL cl3_mode got=%h exp=030", mode_reg); end
        act(2'd1, 12'd5); idle(2);
        wdat[0] = 16'hA5A5; wdqm[0] = 2'b00;
        wr_burst(2'd1, 3, 1'b0, 1); idle(1);
        rd(2'd1, 3, 1'b0);
        nop();
        checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL cl3_early_oe got=%b exp=0", dq_oe); end
        nop();
        checks++; if (dq_oe !== 1'b1 || dq_out !== 16'hA5A5) begin failures++; $display("FAIL cl3_data oe=%b dq=%h exp oe=1 dq=a5a5", dq_oe, dq_out); end
        nop();
        checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL cl3_oe_end got=%b exp=0", dq_oe); end
        checks++; if (err !== 6'h0) begin failures++; $display("FAIL cl3_err got=%b exp=000000", err); end
    endtask

    task automatic test_bl4_burst();
        pre(2'd0, 1'b1); idle(2);
        lmr(12'h022); idle(2);
        act(2'd1, 12'd5); idle(2);
        wdat[0] = 16'hB0B0; wdat[1] = 16'hB1B1; wdat[2] = 16'hB2B2; wdat[3] = 16'hB3B3;
        for (int i = 0; i < 4; i++) wdqm[i] = 2'b00;
        wr_burst(2'd1, 4, 1'b0, 4); idle(1);
        wdat[0] = 16'h0011; wdat[1] = 16'h0022; wdat[2] = 16'h0033; wdat[3] = 16'h0044;
        wdqm[1] = 2'b10;
        wr_burst(2'd1, 6, 1'b0, 4); idle(1);
        exp4[0] = 16'h0011; exp4[1] = 16'hB322; exp4[2] = 16'h0033; exp4[3] = 16'h0044;
        rd(2'd1, 6, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nop();
            checks++;
            if (dq_oe !== 1'b1 || dq_out !== exp4[i]) begin
                failures++; $display("FAIL bl4_beat%0d oe=%b dq=%h exp oe=1 dq=%h", i, dq_oe, dq_out, exp4[i]);
            end
        end
        nop();
        checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL bl4_oe_end got=%b exp=0", dq_oe); end
        checks++; if (err !== 6'h0) begin failures++; $display("FAIL bl4_err got=%b exp=000000", err); end
    endtask

    task automatic test_closed_bank();
        rd(2'd2, 0, 1'b0);
        checks++; if (err !== 6'b000001) begin failures++; $display("FAIL closed_err got=%b exp=000001", err); end
        for (int i = 0; i < 3; i++) begin
            nop();
            checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL closed_oe%0d got=%b exp=0", i, dq_oe); end
        end
        act(2'd1, 12'd7);
        checks++; if (err !== 6'b000011) begin failures++; $display("FAIL reopen_err got=%b exp=000011", err); end
        idle(2);
        rd(2'd1, 3, 1'b0);
        nop();
        checks++; if (dq_oe !== 1'b1 || dq_out !== 16'hA5A5) begin failures++; $display("FAIL keep_row oe=%b dq=%h exp oe=1 dq=a5a5", dq_oe, dq_out); end
        idle(4);
    endtask

    task automatic test_mrs_refresh();
        do_reset();
        act(2'd0, 12'd1); idle(2);
        refr();
        checks++; if (err !== 6'b000100) begin failures++; $display("FAIL ref_open_err got=%b exp=000100", err); end
        checks++; if (refresh_count !== 16'd1) begin failures++; $display("FAIL ref_open_cnt got=%0d exp=1", refresh_count); end
        idle(7);
        do_reset();
        act(2'd0, 12'd1); idle(2);
        lmr(12'h033);
        checks++; if (err !== 6'b000100) begin failures++; $display("FAIL lmr_open_err got=%b exp=000100", err); end
        checks++; if (mode_reg !== 12'h020) begin failures++; $display("FAIL lmr_open_mode got=%h exp=020", mode_reg); end
        idle(2);
        pre(2'd0, 1'b1); idle(2);
        repeat (3) begin refr(); idle(7); end
        checks++; if (refresh_count !== 16'd3) begin failures++; $display("FAIL ref_cnt got=%0d exp=3", refresh_count); end
        checks++; if (err !== 6'b000100) begin failures++; $display("FAIL ref_closed_err got=%b exp=000100", err); end
    endtask

    task automatic test_autoprecharge();
        lmr(12'h021); idle(2);
        act(2'd3, 12'd2); idle(2);
        wdat[0] = 16'h1234; wdat[1] = 16'h5678; wdqm[0] = 2'b00; wdqm[1] = 2'b00;
        wr_burst(2'd3, 8, 1'b0, 2); idle(1);
        rd(2'd3, 8, 1'b1);
        nop();
        checks++; if (dq_oe !== 1'b1 || dq_out !== 16'h1234) begin failures++; $display("FAIL ap_beat0 oe=%b dq=%h exp oe=1 dq=1234", dq_oe, dq_out); end
        nop();
        checks++; if (dq_oe !== 1'b1 || dq_out !== 16'h5678) begin failures++; $display("FAIL ap_beat1 oe=%b dq=%h exp oe=1 dq=5678", dq_oe, dq_out); end
        nop();
        checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL ap_oe_end got=%b exp=0", dq_oe); end
        rd(2'd3, 8, 1'b0);
        checks++; if (err !== 6'b000101) begin failures++; $display("FAIL ap_closed_err got=%b exp=000101", err); end
        idle(2);
        checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL ap_closed_oe got=%b exp=0", dq_oe); end
    endtask

    task automatic test_timing();
        logic [5:0] exp_err;
`ifdef SDRAM_TIMING_CHECK_EN
        exp_err = 6'b010000;
`else
        exp_err = 6'b000000;
`endif
        do_reset();
        act(2'd0, 12'd4); idle(2);
        wdat[0] = 16'hBEEF; wdqm[0] = 2'b00;
        wr_burst(2'd0, 2, 1'b0, 1); idle(1);
        pre(2'd0, 1'b0); idle(2);
        act(2'd0, 12'd4);
        rd(2'd0, 2, 1'b0);
        nop();
        checks++; if (dq_oe !== 1'b1 || dq_out !== 16'hBEEF) begin failures++; $display("FAIL trcd_data oe=%b dq=%h exp oe=1 dq=beef", dq_oe, dq_out); end
        checks++; if (err !== exp_err) begin failures++; $display("FAIL trcd_err got=%b exp=%b", err, exp_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lmr(12'h022); idle(2);
        act(2'd1, 12'd5); idle(2);
        rd(2'd1, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin wdat[i] = 16'h7770 + 16'(i); wdqm[i] = 2'b00; end
        drive(4'b0100, 2'd1, 12'd0, wdat[0], wdqm[0]);
        checks++; if (dq_oe !== 1'b1 || dq_out !== 16'h0033) begin failures++; $display("FAIL trunc_beat0 oe=%b dq=%h exp oe=1 dq=0033", dq_oe, dq_out); end
        drive(4'b0111, 2'd0, '0, wdat[1], wdqm[1]);
        checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL trunc_oe got=%b exp=0", dq_oe); end
        drive(4'b0111, 2'd0, '0, wdat[2], wdqm[2]);
        drive(4'b0111, 2'd0, '0, wdat[3], wdqm[3]);
        checks++; if (err !== 6'b100000) begin failures++; $display("FAIL wr_during_rd_err got=%b exp=100000", err); end
        idle(1);
        rd(2'd1, 0, 1'b0);
        nop();
        checks++; if (dq_oe !== 1'b1 || dq_out !== 16'h7770) begin failures++; $display("FAIL wr_beat0 oe=%b dq=%h exp oe=1 dq=7770", dq_oe, dq_out); end
        idle(3);
        checks++; if (dq_oe !== 1'b1 || dq_out !== 16'h7773) begin failures++; $display("FAIL wr_beat3 oe=%b dq=%h exp oe=1 dq=7773", dq_oe, dq_out); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_cl3_rw();
        test_bl4_burst();
        test_closed_bank();
        test_mrs_refresh();
        test_autoprecharge();
        test_timing();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
